// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient scheduler.
// Contents: datapath/coefficient constants, FSM state encoding, the
// coefficient bank type and a phase-advance helper.
package fir_pkg;

  localparam int C_IN  = 5;               // coefficient width (signed)
  localparam int N_PAR = 6;               // samples per block
  localparam int N_TAP = 4;               // coefficients per bank
  localparam int A_W   = $clog2(N_TAP);   // cfg_addr width
  localparam int PH_W  = 3;               // phase width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef logic signed [C_IN-1:0] coef_bank_t [N_TAP];

  // Phase of the next sample; wraps after the last sample of a block.
  function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] p);
    return (p == PH_W'(N_PAR - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/fir_coef_sched_if.sv
// Coefficient configuration port of the FIR scheduler.
// Signals: cfg_valid/cfg_ready write handshake, cfg_addr tap index,
// cfg_data signed coefficient, cfg_commit swap request, swap_pending status.
// master = configuration source, slave = scheduler.
interface fir_coef_sched_if;

  logic                              cfg_valid;
  logic                              cfg_ready;
  logic [fir_pkg::A_W-1:0]           cfg_addr;
  logic signed [fir_pkg::C_IN-1:0]   cfg_data;
  logic                              cfg_commit;
  logic                              swap_pending;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit,
    input  cfg_ready, swap_pending
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
    output cfg_ready, swap_pending
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register pair.
// Ports: clk, rstn (sync active-low), wr_valid/wr_addr/wr_data shadow write,
// commit (request swap), swap_en (swap allowed this edge),
// swap_pending (commit accepted, swap outstanding), active (live bank).
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_valid,
  input  logic [A_W-1:0]         wr_addr,
  input  logic signed [C_IN-1:0] wr_data,
  input  logic                   commit,
  input  logic                   swap_en,
  output logic                   swap_pending,
  output coef_bank_t             active
);

  coef_bank_t shadow_reg;
  coef_bank_t active_reg;
  logic       pending_reg;
  logic       wr_fire;
  logic       swap_fire;

  // Shadow is frozen while a swap is outstanding, so the bank that gets
  // swapped is exactly the one that was committed.
  assign wr_fire   = wr_valid && !pending_reg;
  assign swap_fire = pending_reg && swap_en;

  genvar gi;
  generate
    for (gi = 0; gi < N_TAP; gi++) begin : g_tap
      always_ff @(posedge clk) begin
        if (!rstn) begin
          shadow_reg[gi] <= '0;
        end else if (wr_fire && (wr_addr == A_W'(gi))) begin
          shadow_reg[gi] <= wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          active_reg[gi] <= '0;
        end else if (swap_fire) begin
          active_reg[gi] <= shadow_reg[gi];
        end
      end

      assign active[gi] = active_reg[gi];
    end
  endgenerate

  // A commit seen while already pending (including on the swap edge) is dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_reg <= 1'b0;
    end else if (swap_fire) begin
      pending_reg <= 1'b0;
    end else if (commit) begin
      pending_reg <= 1'b1;
    end
  end

  assign swap_pending = pending_reg;

endmodule

// File: rtl/fir_coef_sched.sv
// Block scheduler and coefficient controller for the 6-parallel 4-tap FIR.
// Ports: clk, rstn (sync active-low), en (run enable), x_valid (sample in),
// cfg (configuration interface, slave side), c_0..c_3 (live coefficients),
// phase (next sample slot), blk_strobe (block captured), y_valid (block
// output meaningful), state (IDLE/RUN/FLUSH).
module fir_coef_sched
  import fir_pkg::*;
#(
  parameter int FLUSH_BLK = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   x_valid,
  fir_coef_sched_if.slave        cfg,
  output logic signed [C_IN-1:0] c_0,
  output logic signed [C_IN-1:0] c_1,
  output logic signed [C_IN-1:0] c_2,
  output logic signed [C_IN-1:0] c_3,
  output logic [PH_W-1:0]        phase,
  output logic                   blk_strobe,
  output logic                   y_valid,
  output logic [1:0]             state
);

  localparam int FC_W = (FLUSH_BLK < 1) ? 1 : $clog2(FLUSH_BLK + 1);

  state_t            state_reg;
  logic [PH_W-1:0]   phase_reg;
  logic [FC_W-1:0]   flush_cnt_reg;
  logic              blk_strobe_reg;
  logic              y_valid_reg;

  logic              wrap;
  logic              swap_en;
  logic              swap_fire;
  logic              pending;
  coef_bank_t        active;

  // A wrap needs en: dropping en discards the block even on its last sample.
  assign wrap      = (state_reg != ST_IDLE) && en && x_valid &&
                     (phase_reg == PH_W'(N_PAR - 1));
  assign swap_en   = (state_reg == ST_IDLE) || wrap;
  assign swap_fire = pending && swap_en;

  fir_coef_bank u_bank (
    .clk          (clk),
    .rstn         (rstn),
    .wr_valid     (cfg.cfg_valid),
    .wr_addr      (cfg.cfg_addr),
    .wr_data      (cfg.cfg_data),
    .commit       (cfg.cfg_commit),
    .swap_en      (swap_en),
    .swap_pending (pending),
    .active       (active)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= '0;
      flush_cnt_reg  <= '0;
      blk_strobe_reg <= 1'b0;
      y_valid_reg    <= 1'b0;
    end else begin
      blk_strobe_reg <= wrap;
      // Only a RUN block that is not the swap block carries fresh history.
      y_valid_reg    <= wrap && (state_reg == ST_RUN) && !swap_fire;

      case (state_reg)
        ST_IDLE: begin
          phase_reg <= '0;
          if (en) begin
            state_reg     <= ST_FLUSH;
            flush_cnt_reg <= FC_W'(FLUSH_BLK);
          end
        end
        default: begin
          if (!en) begin
            state_reg <= ST_IDLE;
            phase_reg <= '0;
          end else begin
            if (x_valid) begin
              phase_reg <= next_phase(phase_reg);
            end
            if (swap_fire) begin
              state_reg     <= ST_FLUSH;
              flush_cnt_reg <= FC_W'(FLUSH_BLK);
            end else if (wrap && (state_reg == ST_FLUSH)) begin
              // A count of 0 or 1 means this wrap ends the flush.
              if (flush_cnt_reg <= FC_W'(1)) begin
                state_reg <= ST_RUN;
              end
              flush_cnt_reg <= (flush_cnt_reg == '0) ? '0 : flush_cnt_reg - FC_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign cfg.swap_pending = pending;
  assign cfg.cfg_ready    = !pending;

  assign c_0        = active[0];
  assign c_1        = active[1];
  assign c_2        = active[2];
  assign c_3        = active[3];
  assign phase      = phase_reg;
  assign blk_strobe = blk_strobe_reg;
  assign y_valid    = y_valid_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_fir_coef_sched.sv
module tb_fir_coef_sched;

  logic              clk = 1'b0;
  logic              rstn;
  logic              en;
  logic              x_valid;
  logic signed [4:0] c_0, c_1, c_2, c_3;
  logic [2:0]        phase;
  logic              blk_strobe;
  logic              y_valid;
  logic [1:0]        state;

  fir_coef_sched_if cfg_if ();

  fir_coef_sched #(.FLUSH_BLK(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .x_valid    (x_valid),
    .cfg        (cfg_if),
    .c_0        (c_0),
    .c_1        (c_1),
    .c_2        (c_2),
    .c_3        (c_3),
    .phase      (phase),
    .blk_strobe (blk_strobe),
    .y_valid    (y_valid),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        yv;
    logic [19:0] coefs;
  } sb_t;

  sb_t               sb[$];
  int                checks   = 0;
  int                failures = 0;
  logic signed [4:0] exp_c [4];
  logic [2:0]        exp_phase;
  logic              exp_yv_next;

  function automatic logic [19:0] pack_c();
    return {exp_c[3], exp_c[2], exp_c[1], exp_c[0]};
  endfunction

  // Scoreboard consumer: every strobe must match a block the stimulus completed.
  always @(negedge clk) begin
    sb_t e;
    if (blk_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_strobe at %0t (no block pending)", $time);
      end else begin
        e = sb.pop_front();
        checks++;
        if (y_valid !== e.yv) begin
          failures++;
          $display("FAIL strobe_y_valid got=%b exp=%b at %0t", y_valid, e.yv, $time);
        end
        checks++;
        if ({c_3, c_2, c_1, c_0} !== e.coefs) begin
          failures++;
          $display("FAIL strobe_coefs got=%h exp=%h at %0t", {c_3, c_2, c_1, c_0}, e.coefs, $time);
        end
        $display("strobe t=%0t y_valid=%b c=%0d,%0d,%0d,%0d", $time, y_valid, c_0, c_1, c_2, c_3);
      end
    end else begin
      checks++;
      if (y_valid !== 1'b0) begin
        failures++;
        $display("FAIL y_valid_without_strobe got=%b at %0t", y_valid, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input logic xv);
    sb_t e;
    x_valid = xv;
    if (xv && exp_phase == 3'd5) begin
      e.yv    = exp_yv_next;
      e.coefs = pack_c();
      sb.push_back(e);
    end
    step();
    if (xv) exp_phase = (exp_phase == 3'd5) ? 3'd0 : exp_phase + 3'd1;
  endtask

  task automatic cfg_idle();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; x_valid = 1'b0; cfg_idle();
    cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
    step(); step();
    rstn = 1'b1;
    exp_phase = 3'd0;
    for (int i = 0; i < 4; i++) exp_c[i] = '0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    checks++; if (blk_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", blk_strobe); end
    checks++; if (cfg_if.swap_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", cfg_if.swap_pending); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
    checks++; if ({c_3, c_2, c_1, c_0} !== 20'h0) begin failures++; $display("FAIL reset_coefs got=%h exp=0", {c_3, c_2, c_1, c_0}); end
    $display("reset done");
  endtask

  task automatic test_config_idle();
    logic signed [4:0] vals [4];
    vals[0] = 5'sd3; vals[1] = -5'sd2; vals[2] = 5'sd7; vals[3] = -5'sd16;
    for (int i = 0; i < 4; i++) begin
      cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 2'(i); cfg_if.cfg_data = vals[i];
      step();
    end
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_commit = 1'b1;
    step();
    cfg_idle();
    checks++; if (cfg_if.swap_pending !== 1'b1) begin failures++; $display("FAIL idle_pending_set got=%b exp=1", cfg_if.swap_pending); end
    checks++; if (c_0 !== 5'sd0) begin failures++; $display("FAIL idle_c0_before_swap got=%0d exp=0", c_0); end
    step();
    for (int i = 0; i < 4; i++) exp_c[i] = vals[i];
    checks++; if (cfg_if.swap_pending !== 1'b0) begin failures++; $display("FAIL idle_pending_clear got=%b exp=0", cfg_if.swap_pending); end
    checks++; if ({c_3, c_2, c_1, c_0} !== pack_c()) begin failures++; $display("FAIL idle_swap_coefs got=%h exp=%h", {c_3, c_2, c_1, c_0}, pack_c()); end
    $display("idle config swap c=%0d,%0d,%0d,%0d", c_0, c_1, c_2, c_3);
  endtask

  task automatic test_run_stream();
    logic w;
    en = 1'b1;
    step();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL start_state got=%0d exp=2", state); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL start_phase got=%0d exp=0", phase); end
    for (int i = 0; i < 18; i++) begin
      exp_yv_next = (i >= 6);
      w = (exp_phase == 3'd5);
      adv(1'b1);
      checks++; if (phase !== exp_phase) begin failures++; $display("FAIL stream_phase i=%0d got=%0d exp=%0d", i, phase, exp_phase); end
      checks++; if (blk_strobe !== w) begin failures++; $display("FAIL stream_strobe i=%0d got=%b exp=%b", i, blk_strobe, w); end
      if (i == 5) begin
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL flush_exit_state got=%0d exp=1", state); end
      end
    end
    $display("stream of 3 blocks done");
  endtask

  task automatic test_swap_run();
    exp_yv_next = 1'b0;
    adv(1'b1); adv(1'b1);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 2'd1; cfg_if.cfg_data = 5'sd5; cfg_if.cfg_commit = 1'b1;
    adv(1'b1);
    cfg_idle();
    checks++; if (cfg_if.swap_pending !== 1'b1) begin failures++; $display("FAIL run_pending got=%b exp=1", cfg_if.swap_pending); end
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL run_ready got=%b exp=0", cfg_if.cfg_ready); end
    checks++; if (c_1 !== exp_c[1]) begin failures++; $display("FAIL run_c1_early got=%0d exp=%0d", c_1, exp_c[1]); end
    adv(1'b1); adv(1'b1);
    checks++; if (c_1 !== exp_c[1]) begin failures++; $display("FAIL run_c1_hold got=%0d exp=%0d", c_1, exp_c[1]); end
    exp_c[1] = 5'sd5;
    adv(1'b1);
    checks++; if (cfg_if.swap_pending !== 1'b0) begin failures++; $display("FAIL run_pending_clear got=%b exp=0", cfg_if.swap_pending); end
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL swap_state got=%0d exp=2", state); end
    for (int i = 0; i < 6; i++) adv(1'b1);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL post_flush_state got=%0d exp=1", state); end
    exp_yv_next = 1'b1;
    for (int i = 0; i < 6; i++) adv(1'b1);
    $display("run swap done c_1=%0d", c_1);
  endtask

  task automatic test_same_cycle();
    exp_yv_next = 1'b0;
    adv(1'b1);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 2'd3; cfg_if.cfg_data = -5'sd1; cfg_if.cfg_commit = 1'b1;
    adv(1'b1);
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL same_ready got=%b exp=0", cfg_if.cfg_ready); end
    cfg_if.cfg_addr = 2'd0; cfg_if.cfg_data = 5'sd9;
    adv(1'b1);
    cfg_idle();
    adv(1'b1); adv(1'b1);
    exp_c[3] = -5'sd1;
    adv(1'b1);
    checks++; if (c_3 !== -5'sd1) begin failures++; $display("FAIL same_c3 got=%0d exp=-1", c_3); end
    checks++; if (cfg_if.swap_pending !== 1'b0) begin failures++; $display("FAIL second_commit_ignored got=%b exp=0", cfg_if.swap_pending); end
    for (int i = 0; i < 6; i++) adv(1'b1);
    checks++; if (cfg_if.swap_pending !== 1'b0) begin failures++; $display("FAIL no_second_swap got=%b exp=0", cfg_if.swap_pending); end
    checks++; if (c_0 !== exp_c[0]) begin failures++; $display("FAIL blocked_write_c0 got=%0d exp=%0d", c_0, exp_c[0]); end
    $display("same-cycle write+commit done c_3=%0d", c_3);
  endtask

  task automatic test_gapped();
    logic w;
    logic xv;
    exp_yv_next = 1'b1;
    for (int i = 0; i < 18; i++) begin
      xv = ((i % 3) == 0);
      w  = xv && (exp_phase == 3'd5);
      adv(xv);
      checks++; if (phase !== exp_phase) begin failures++; $display("FAIL gap_phase i=%0d got=%0d exp=%0d", i, phase, exp_phase); end
      checks++; if (blk_strobe !== w) begin failures++; $display("FAIL gap_strobe i=%0d got=%b exp=%b", i, blk_strobe, w); end
    end
    $display("gapped block done");
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < 4; i++) adv(1'b1);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 2'd2; cfg_if.cfg_data = -5'sd5; cfg_if.cfg_commit = 1'b1;
    adv(1'b0);
    cfg_idle();
    checks++; if (cfg_if.swap_pending !== 1'b1) begin failures++; $display("FAIL drop_pending_set got=%b exp=1", cfg_if.swap_pending); end
    en = 1'b0; x_valid = 1'b1;
    step();
    exp_phase = 3'd0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL drop_state got=%0d exp=0", state); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL drop_phase got=%0d exp=0", phase); end
    checks++; if (cfg_if.swap_pending !== 1'b1) begin failures++; $display("FAIL drop_pending_kept got=%b exp=1", cfg_if.swap_pending); end
    step();
    x_valid = 1'b0;
    exp_c[2] = -5'sd5;
    checks++; if (cfg_if.swap_pending !== 1'b0) begin failures++; $display("FAIL drop_swap_done got=%b exp=0", cfg_if.swap_pending); end
    checks++; if (c_2 !== -5'sd5) begin failures++; $display("FAIL drop_c2 got=%0d exp=-5", c_2); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL idle_phase_hold got=%0d exp=0", phase); end
    $display("en drop done c_2=%0d", c_2);
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    step();
    exp_yv_next = 1'b0;
    for (int i = 0; i < 3; i++) adv(1'b1);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 2'd0; cfg_if.cfg_data = 5'sd1; cfg_if.cfg_commit = 1'b1;
    adv(1'b0);
    cfg_idle();
    checks++; if (cfg_if.swap_pending !== 1'b1) begin failures++; $display("FAIL mid_pending_set got=%b exp=1", cfg_if.swap_pending); end
    rstn = 1'b0; x_valid = 1'b1;
    step();
    rstn = 1'b1; en = 1'b0; x_valid = 1'b0;
    exp_phase = 3'd0;
    for (int i = 0; i < 4; i++) exp_c[i] = '0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL mid_state got=%0d exp=0", state); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL mid_phase got=%0d exp=0", phase); end
    checks++; if (blk_strobe !== 1'b0) begin failures++; $display("FAIL mid_strobe got=%b exp=0", blk_strobe); end
    checks++; if (cfg_if.swap_pending !== 1'b0) begin failures++; $display("FAIL mid_pending got=%b exp=0", cfg_if.swap_pending); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", cfg_if.cfg_ready); end
    checks++; if ({c_3, c_2, c_1, c_0} !== 20'h0) begin failures++; $display("FAIL mid_coefs got=%h exp=0", {c_3, c_2, c_1, c_0}); end
    // Shadow must be cleared as well: swapping it in leaves the bank at zero.
    cfg_if.cfg_commit = 1'b1;
    step();
    cfg_idle();
    step();
    checks++; if ({c_3, c_2, c_1, c_0} !== 20'h0) begin failures++; $display("FAIL mid_shadow_cleared got=%h exp=0", {c_3, c_2, c_1, c_0}); end
    $display("mid-block reset done");
  endtask

  initial begin
    test_reset();
    test_config_idle();
    test_run_stream();
    test_swap_run();
    test_same_cycle();
    test_gapped();
    test_en_drop();
    test_reset_mid();
    step(); step(); step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
